// File: rtl/puf_response_reader.sv
// RO-PUF response reader: steps NBITS challenges through the oscillator banks,
// times clear / enable / settle windows, and compares the frozen counts into a
// response word plus a tie count. Counts are only sampled after the oscillators
// have stopped and settled, so no synchronizer is used on count_a/count_b.
module puf_response_reader #(
  parameter int CW      = 8,
  parameter int SELW    = 3,
  parameter int NBITS   = 8,
  parameter int WINDOW  = 64,
  parameter int SETTLE  = 4,
  parameter int CLR_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,    // active-high async reset
  input  logic                         start,
  input  logic [SELW-1:0]              chal_base,
  input  logic [CW-1:0]                count_a,
  input  logic [CW-1:0]                count_b,
  output logic [SELW-1:0]              challenge,
  output logic                         osc_en,
  output logic                         cnt_clr,
  output logic                         busy,
  output logic                         done,
  output logic [NBITS-1:0]             response,
  output logic [$clog2(NBITS+1)-1:0]   tie_cnt
);

  localparam int TMAX = (WINDOW > SETTLE) ? ((WINDOW > CLR_CYC) ? WINDOW : CLR_CYC)
                                          : ((SETTLE > CLR_CYC) ? SETTLE : CLR_CYC);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int TCW  = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_STOP, S_CAPTURE, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_tmr;
  logic [IW-1:0]   r_idx;
  logic            w_last;

  assign w_last = (r_idx == IW'(NBITS - 1));

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: each timed phase leaves on the last cycle of its window
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start)                        w_state_nxt = S_CLEAR;
      S_CLEAR:   if (r_tmr == TW'(CLR_CYC - 1))    w_state_nxt = S_RUN;
      S_RUN:     if (r_tmr == TW'(WINDOW - 1))     w_state_nxt = S_STOP;
      S_STOP:    if (r_tmr == TW'(SETTLE - 1))     w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = w_last ? S_DONE : S_CLEAR;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Phase timer: restarts on every state change, idles at zero in IDLE
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                       r_tmr <= '0;
    else if (w_state_nxt != r_state) r_tmr <= '0;
    else if (r_state != S_IDLE)      r_tmr <= r_tmr + TW'(1);
  end

  // Registered outputs decoded from the next state, plus response assembly
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      osc_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      challenge <= '0;
      response  <= '0;
      tie_cnt   <= '0;
      r_idx     <= '0;
    end else begin
      osc_en  <= (w_state_nxt == S_RUN);
      cnt_clr <= (w_state_nxt == S_CLEAR);
      done    <= (w_state_nxt == S_DONE);
      busy    <= (w_state_nxt inside {S_CLEAR, S_RUN, S_STOP, S_CAPTURE});
      if (r_state == S_IDLE && start) begin
        challenge <= chal_base;
        response  <= '0;
        tie_cnt   <= '0;
        r_idx     <= '0;
      end
      if (r_state == S_CAPTURE) begin
        response[r_idx] <= (count_a > count_b);
        if (count_a == count_b) tie_cnt <= tie_cnt + TCW'(1);
        // challenge tracks chal_base + idx and wraps naturally at SELW bits
        if (!w_last) begin
          r_idx     <= r_idx + IW'(1);
          challenge <= challenge + SELW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_response_reader.sv
// Bench for puf_response_reader: per-challenge count tables drive the frozen
// counts in each capture cycle, a scoreboard queue holds the expected response
// per run, and a monitor checks results and protocol windows as they appear.
module tb_puf_response_reader;
  localparam int CW = 8, SELW = 3, NBITS = 8, WINDOW = 64, SETTLE = 4, CLR_CYC = 2;
  localparam int NCH     = 1 << SELW;
  localparam int BIT_CYC = CLR_CYC + WINDOW + SETTLE + 1;
  localparam int RUN_CYC = NBITS * BIT_CYC;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [SELW-1:0] chal_base = '0;
  logic [CW-1:0] count_a = '0, count_b = '0;
  logic [SELW-1:0] challenge;
  logic osc_en, cnt_clr, busy, done;
  logic [NBITS-1:0] response;
  logic [$clog2(NBITS+1)-1:0] tie_cnt;

  puf_response_reader #(.CW(CW), .SELW(SELW), .NBITS(NBITS), .WINDOW(WINDOW),
                        .SETTLE(SETTLE), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal_base(chal_base),
    .count_a(count_a), .count_b(count_b), .challenge(challenge), .osc_en(osc_en),
    .cnt_clr(cnt_clr), .busy(busy), .done(done), .response(response), .tie_cnt(tie_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [NBITS-1:0] resp; int tie; int k; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_pass = 0, n_done = 0;
  logic [CW-1:0] ta [NCH];
  logic [CW-1:0] tbv[NCH];
  int cur_base = 0, bidx = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Count driver: real values only in the capture cycle (SETTLE+1 cycles after
  // osc_en falls); random garbage everywhere else must not matter.
  int s_drv = -1, drv_c = 0;
  always @(negedge clk) begin
    if (rst_n) s_drv = -1;
    else begin
      if (osc_en) s_drv = 0;
      else if (s_drv >= 0) s_drv++;
      if (s_drv == SETTLE + 1) begin
        drv_c = (cur_base + bidx) % NCH;
        chk("challenge", challenge, drv_c);
        count_a = ta[drv_c];
        count_b = tbv[drv_c];
        bidx++;
        s_drv = -1;
      end else begin
        count_a = CW'($urandom);
        count_b = CW'($urandom);
      end
    end
  end

  // Monitor: protocol window lengths and scoreboard comparison on done
  int clr_len = 0, osc_len = 0, gap = -1;
  logic p_clr = 1'b0, p_osc = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      clr_len = 0; osc_len = 0; gap = -1; p_clr = 1'b0; p_osc = 1'b0;
    end else begin
      if (busy) chk("clr_osc_overlap", cnt_clr & osc_en, 0);
      if (cnt_clr) clr_len++;
      else if (p_clr) begin chk("clr_len", clr_len, CLR_CYC); clr_len = 0; end
      if (osc_en) osc_len++;
      else if (p_osc) begin chk("osc_len", osc_len, WINDOW); osc_len = 0; gap = 0; end
      if (gap >= 0) begin
        if (cnt_clr || done) begin chk("settle_gap", gap, SETTLE + 1); gap = -1; end
        else gap++;
      end
      if (done) begin
        n_done++;
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_e = q.pop_front();
          chk("response", response, mon_e.resp);
          chk("tie_cnt", tie_cnt, mon_e.tie);
          chk("done_cycle", cyc, mon_e.k + RUN_CYC);
          chk("busy_at_done", busy, 0);
        end
      end
      p_clr = cnt_clr;
      p_osc = osc_en;
    end
  end

  // Reference: bit i compares the table entry of challenge (base+i) mod 2^SELW
  task automatic issue(input int base, output int k);
    exp_t e;
    int c;
    e.resp = '0; e.tie = 0;
    for (int i = 0; i < NBITS; i++) begin
      c = (base + i) % NCH;
      e.resp[i] = (ta[c] > tbv[c]);
      if (ta[c] == tbv[c]) e.tie++;
    end
    @(negedge clk);
    chal_base = SELW'(base); start = 1'b1; cur_base = base; bidx = 0;
    k = cyc + 1; e.k = k; q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 3 * RUN_CYC) begin @(negedge clk); t++; end
    chk("done_in_time", n_done >= target, 1);
  endtask

  task automatic fill_rand();
    for (int c = 0; c < NCH; c++) begin
      ta[c]  = CW'($urandom_range(0, 255));
      tbv[c] = ($urandom_range(0, 3) == 0) ? ta[c] : CW'($urandom_range(0, 255));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_osc_en"}, osc_en, 0);
    chk({tag, "_cnt_clr"}, cnt_clr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_challenge"}, challenge, 0);
    chk({tag, "_response"}, response, 0);
    chk({tag, "_tie_cnt"}, tie_cnt, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd, t;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // basic: A always faster
    for (int c = 0; c < NCH; c++) begin ta[c] = 8'd100; tbv[c] = 8'd50; end
    issue(0, k); wait_done(1);
    chk("basic_resp", response, 8'hFF);

    // mixed bits: only challenges 1,4,6 favour A
    for (int c = 0; c < NCH; c++) begin
      ta[c] = (c == 1 || c == 4 || c == 6) ? 8'd200 : 8'd10; tbv[c] = 8'd100;
    end
    issue(0, k); wait_done(2);
    chk("mixed_resp", response, 8'h52);

    // ties plus challenge wrap from base 6
    for (int c = 0; c < NCH; c++) begin
      ta[c]  = (c >= 6) ? 8'd33 : 8'd90;
      tbv[c] = (c >= 6) ? 8'd33 : 8'd20;
    end
    issue(6, k); wait_done(3);
    chk("tie_resp", response, 8'hFC);
    chk("tie_count", tie_cnt, 2);
    chk("hold_after_done", response, 8'hFC);

    // start while busy, then start during the DONE cycle: both ignored
    fill_rand();
    issue(int'($urandom_range(0, NCH - 1)), k);
    repeat (98) @(negedge clk);
    chal_base = SELW'($urandom); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!done && t < 3 * RUN_CYC) begin @(negedge clk); t++; end
    chk("done_seen", done, 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin chk("idle_after_done_start", busy, 0); @(negedge clk); end
    nd = n_done;
    repeat (RUN_CYC + 20) @(negedge clk);
    chk("no_extra_done", n_done, nd);

    // mid-run reset at cycle 200 of a run
    fill_rand();
    issue(int'($urandom_range(0, NCH - 1)), k);
    while (cyc < k + 199) @(negedge clk);
    chk("osc_en_before_reset", osc_en, 1);
    rst_n = 1'b1;
    #1;
    check_reset_vals("async_reset");
    q.delete();
    nd = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (RUN_CYC + 20) @(negedge clk);
    chk("no_done_after_abort", n_done, nd);

    // fresh randomized runs
    for (int r = 0; r < 6; r++) begin
      fill_rand();
      issue(int'($urandom_range(0, NCH - 1)), k);
      wait_done(nd + 1 + r);
      repeat (int'($urandom_range(0, 5))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/puf_response_reader.md
Name: puf_response_reader

Overview:
- Control-side reader for the RO-PUF challenge/response datapath.
- Sequences NBITS challenges on the oscillator-select lines. For each challenge it clears the two ring-oscillator ripple counters, gates the oscillators for a fixed window, freezes them, then samples and compares the two frozen counts.
- Each comparison produces one response bit. The bits are assembled into a response word with a tie counter, for the host or the output mux.
- The ripple counters are clocked by the oscillators, not clk. Counts are sampled only after the oscillators have been stopped and the counts have settled, so no synchronizer is needed.

Parameters:
- CW, 8, width of count_a/count_b
- SELW, 3, width of challenge select
- NBITS, 8, challenges per run = response width
- WINDOW, 64, clk cycles osc_en is held high per challenge (>=1)
- SETTLE, 4, clk cycles after osc_en falls before sampling (>=2)
- CLR_CYC, 2, clk cycles cnt_clr is held high before each window (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-high (1 = reset), per the codebase's rst_n convention
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- chal_base  in  SELW  first challenge of the run; captured on accepted start
- count_a  in  CW  frozen count of oscillator bank A
- count_b  in  CW  frozen count of oscillator bank B
- challenge  out  SELW  oscillator select driven to both banks
- osc_en  out  1  oscillator enable (drives ena of both banks)
- cnt_clr  out  1  counter clear (drives counter reset of both banks, active-high)
- busy  out  1  high from CLEAR of bit 0 through CAPTURE of the last bit
- done  out  1  one-cycle pulse after the last capture
- response  out  NBITS  assembled response; bit i = result of challenge i
- tie_cnt  out  $clog2(NBITS+1)  number of challenges with count_a == count_b

Behaviour:
- Reset values (async, immediate): state=IDLE, osc_en=0, cnt_clr=0, challenge=0, busy=0, done=0, response=0, tie_cnt=0, idx=0.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 captures chal_base, clears response and tie_cnt, sets idx=0, goes to CLEAR.
  - CLEAR: cnt_clr=1, osc_en=0 for CLR_CYC cycles, then RUN.
  - RUN: osc_en=1 for exactly WINDOW cycles, then STOP.
  - STOP: osc_en=0 for SETTLE cycles, then CAPTURE.
  - CAPTURE: one cycle. Sets response[idx] = (count_a > count_b), unsigned compare. If count_a == count_b, the bit is 0 and tie_cnt increments. If idx == NBITS-1, go to DONE; else idx++ and go to CLEAR.
  - DONE: done=1 for one cycle, then IDLE.
- challenge = (chal_base + idx) mod 2^SELW. It is updated on entry to CLEAR and stable through CAPTURE. It wraps: base 7, idx 1 gives 0.
- cnt_clr and osc_en are never high in the same cycle.
- Per-bit cost is CLR_CYC+WINDOW+SETTLE+1 cycles.
- Defaults: 71 cycles per bit, 568 per run. With start accepted at edge k:
  - busy is high in cycles k+1..k+568.
  - done is high in cycle k+569.
- Counter overflow wraps inside the counters and is not detected. WINDOW is chosen so counts stay below 2^CW.
- start while not IDLE is ignored. start in the DONE cycle is ignored.
- response and tie_cnt hold their values after DONE until the next accepted start.
- rst_n mid-run aborts immediately: osc_en drops asynchronously and all outputs take reset values. No done pulse is issued.
- count_a/count_b are ignored in every state except CAPTURE.

Test Plan:
- Basic run (defaults, chal_base=0): model drives count_a=100, count_b=50 on every challenge; pulse start -> challenge steps 0..7, osc_en high 64 cycles per step, response=8'hFF, tie_cnt=0, done pulse exactly 569 cycles after start.
- Mixed bits: count_a > count_b only for challenges 1, 4 and 6, count_a < count_b otherwise -> response=8'h52, tie_cnt=0.
- Ties and wrap: chal_base=6, count_a==count_b=33 for challenges 6 and 7, count_a > count_b otherwise -> challenge order 6,7,0,1,...,5; response=8'hFC; tie_cnt=2.
- Protocol timing: check every bit period for CLR_CYC=2 cnt_clr cycles, then 64 osc_en cycles, then 4 idle cycles; cnt_clr&osc_en never 1; count inputs changed outside CAPTURE do not affect the result.
- Start while busy: second start at cycle 100 -> ignored, single done at cycle 569; start during the DONE cycle -> ignored, stays IDLE.
- Mid-run reset: assert rst_n at cycle 200 -> osc_en=0 the same cycle without waiting for a clk edge, all outputs at reset values, no done; a fresh start afterwards completes normally.
